// File: rtl/ps2_dir_decoder.sv
// rtl/ps2_dir_decoder.sv - PS/2 scan-code parser producing held direction keys and a FWFT press-event FIFO
module ps2_dir_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int PTR_W          = 2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             ps2_key_pressed,
  input  logic [7:0]       ps2_key_data,
  input  logic             ev_rd,
  input  logic             ev_clr,
  output logic [3:0]       held,
  output logic [1:0]       ev_dir,
  output logic             ev_empty,
  output logic [PTR_W:0]   ev_count,
  output logic             overflow
);

  localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [PTR_W:0]    DEPTH_L  = (PTR_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic make_v;
  logic brk_v;
  logic ext_v;

  // Parser: prefixes only move the state; a non-prefix byte completes a make or break.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    make_v  = 1'b0;
    brk_v   = 1'b0;
    ext_v   = 1'b0;
    if (ps2_key_pressed) begin
      cnt_d = '0;
      unique case (state_q)
        S_IDLE: begin
          if (ps2_key_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (ps2_key_data == 8'hF0) begin
            state_d = S_BRK;
          end else begin
            make_v = 1'b1;
          end
        end
        S_EXT: begin
          if (ps2_key_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else if (ps2_key_data == 8'hE0) begin
            state_d = S_EXT;
          end else begin
            make_v  = 1'b1;
            ext_v   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_BRK: begin
          if (ps2_key_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (ps2_key_data == 8'hF0) begin
            state_d = S_BRK;
          end else begin
            brk_v   = 1'b1;
            state_d = S_IDLE;
          end
        end
        S_EXT_BRK: begin
          if (ps2_key_data == 8'hE0) begin
            state_d = S_EXT;
          end else if (ps2_key_data == 8'hF0) begin
            state_d = S_EXT_BRK;
          end else begin
            brk_v   = 1'b1;
            ext_v   = 1'b1;
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (state_q != S_IDLE) begin
      if (cnt_q == CNT_LAST) begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  logic       key_hit;
  logic [1:0] key_idx;

  // Arrows only count with the E0 prefix; WASD only without it.
  always_comb begin
    key_hit = 1'b0;
    key_idx = 2'd0;
    if (ext_v) begin
      unique case (ps2_key_data)
        8'h75:   begin key_hit = 1'b1; key_idx = 2'd0; end
        8'h72:   begin key_hit = 1'b1; key_idx = 2'd1; end
        8'h6B:   begin key_hit = 1'b1; key_idx = 2'd2; end
        8'h74:   begin key_hit = 1'b1; key_idx = 2'd3; end
        default: key_hit = 1'b0;
      endcase
    end else begin
      unique case (ps2_key_data)
        8'h1D:   begin key_hit = 1'b1; key_idx = 2'd0; end
        8'h1B:   begin key_hit = 1'b1; key_idx = 2'd1; end
        8'h1C:   begin key_hit = 1'b1; key_idx = 2'd2; end
        8'h23:   begin key_hit = 1'b1; key_idx = 2'd3; end
        default: key_hit = 1'b0;
      endcase
    end
  end

  logic [3:0] arrow_q, arrow_d;
  logic [3:0] wasd_q, wasd_d;
  logic [3:0] held_nxt;
  logic       push;

  always_comb begin
    arrow_d = arrow_q;
    wasd_d  = wasd_q;
    if (key_hit && (make_v || brk_v)) begin
      if (ext_v) begin
        arrow_d[key_idx] = make_v;
      end else begin
        wasd_d[key_idx] = make_v;
      end
    end
  end

  // Only a 0->1 edge of the combined direction is an event; one byte touches one flag.
  assign held_nxt = arrow_d | wasd_d;
  assign push     = |(held_nxt & ~held);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      arrow_q <= '0;
      wasd_q  <= '0;
    end else begin
      arrow_q <= arrow_d;
      wasd_q  <= wasd_d;
    end
  end

  assign held = arrow_q | wasd_q;

  logic [1:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d;
  logic [PTR_W-1:0] rd_q, rd_d;
  logic [PTR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             pop;
  logic             full;
  logic             push_ok;

  assign pop     = ev_rd && (count_q != '0);
  assign full    = (count_q == DEPTH_L);
  assign push_ok = push && (!full || pop);

  always_comb begin
    wr_d    = wr_q;
    rd_d    = rd_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    if (ev_clr) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      if (push_ok) begin
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d = rd_q + 1'b1;
      end
      count_d = count_q + (PTR_W + 1)'(push_ok) - (PTR_W + 1)'(pop);
      if (push && full && !pop) begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_ok && !ev_clr) begin
      mem_q[wr_q] <= key_idx;
    end
  end

  // Storage is not reset, so the head is masked while empty.
  assign ev_empty = (count_q == '0);
  assign ev_dir   = ev_empty ? 2'b00 : mem_q[rd_q];
  assign ev_count = count_q;
  assign overflow = ovf_q;

endmodule

// File: doc/ps2_dir_decoder.md
Name: ps2_dir_decoder

Overview:
Consumes raw PS/2 scan-code bytes from the keyboard interface (byte plus one-cycle strobe) and turns them into Pacman direction state for the processor. Parses make, break (F0) and extended (E0) prefixes. Tracks which direction keys are held. Queues each new direction press into a small first-word-fall-through event FIFO that the processor pops. Sits between the PS/2 interface and the processor/memory-mapped I/O, alongside the existing debouncer/LCD path.

Parameters:
FIFO_DEPTH, 4, event FIFO entries (power of 2, 2..16)
PTR_W, 2, log2(FIFO_DEPTH)
TIMEOUT_CYCLES, 1000000, max cycles allowed between a prefix byte and its following byte (20 ms at 50 MHz)

Ports:
clock  input  1  system clock, all logic rising-edge
resetn  input  1  asynchronous active-low reset
ps2_key_pressed  input  1  one-cycle strobe: ps2_key_data valid this cycle
ps2_key_data  input  8  received scan-code byte
ev_rd  input  1  pop FIFO head (ignored when empty)
ev_clr  input  1  synchronous flush of FIFO and overflow flag
held  output  4  {right,left,down,up} currently held
ev_dir  output  2  FIFO head direction: 00 up, 01 down, 10 left, 11 right
ev_empty  output  1  FIFO empty
ev_count  output  PTR_W+1  entries in FIFO
overflow  output  1  sticky: a press event was dropped because the FIFO was full

Behaviour:
- Reset (resetn=0, async): parser state IDLE, timeout counter 0, all held bits 0, FIFO pointers 0, ev_empty=1, ev_count=0, ev_dir=00, overflow=0. Reset mid-prefix discards the prefix.
- Parser FSM, advances only on cycles with ps2_key_pressed=1:
  IDLE: E0->EXT; F0->BRK; other byte -> make(code, ext=0), stay IDLE.
  EXT: F0->EXT_BRK; E0->EXT; other -> make(code, ext=1), ->IDLE.
  BRK: E0->EXT (restart); F0->BRK; other -> break(code, ext=0), ->IDLE.
  EXT_BRK: E0->EXT; F0->EXT_BRK; other -> break(code, ext=1), ->IDLE.
- Timeout: in any non-IDLE state, the counter increments each cycle without a strobe and resets to 0 on a strobe. When it reaches TIMEOUT_CYCLES-1, the FSM returns to IDLE and the counter clears. In IDLE the counter holds 0.
- Key map. Extended: 75 up, 72 down, 6B left, 74 right. Non-extended: 1D up (W), 1B down (S), 1C left (A), 23 right (D). Unmapped codes, non-extended 75/72/6B/74 (keypad), and extended 1D/1B/1C/23 have no effect.
- Eight internal held flags (4 arrow, 4 WASD). A make sets its flag; a break clears it. held[i] = arrow flag OR WASD flag for that direction.
- Event generation: a push is requested only when a held[i] bit rises 0->1. Typematic repeats of an already-held key, or pressing W while Up is held, generate nothing. At most one push per byte.
- Latency: a strobe at cycle N updates held and pushes to the FIFO so both are visible at N+1; ev_empty falls at N+1.
- FIFO, FWFT: ev_dir always shows the head. ev_rd with ev_empty=0 at cycle N advances the head at N+1. ev_rd while empty is ignored.
- Full: a push with ev_count==FIFO_DEPTH and no simultaneous pop is dropped and sets overflow. A push and pop together when full both succeed and count is unchanged. A push and pop together when empty: the push succeeds, the pop is ignored, count=1.
- ev_clr: next cycle count=0, ev_empty=1, overflow=0, pointers reset. It has priority over a same-cycle push/pop; a same-cycle push is discarded. held and parser state are unaffected.
- Pointers wrap modulo FIFO_DEPTH. ev_count is the exact occupancy, 0..FIFO_DEPTH.

Test Plan:
- Reset, then bytes E0,75 -> held=0001, ev_count=1, ev_dir=00 one cycle after the 75 strobe. Then E0,F0,75 -> held=0000, ev_count stays 1.
- 1C,1C,1C (typematic) -> exactly one event, ev_dir=10. Then E0,6B while A is still held -> no new event. F0,1C -> held[2] stays 1. E0,F0,6B -> held=0000.
- Press/release up, down, left, right, up (WASD) with DEPTH=4 -> first four queued as 00,01,10,11, fifth dropped, overflow=1. Then ev_rd x4 -> ev_dir sequence 00,01,10,11, ev_empty=1. Then ev_clr -> overflow=0.
- Full FIFO, new press and ev_rd in the same cycle -> ev_count stays 4, new entry at tail, head advances.
- Bytes E0 then no strobe for TIMEOUT_CYCLES (parameter set to 16) -> FSM back to IDLE. Then 75 (keypad 8) -> no event, held=0000.
- Bytes E0,F0 then resetn pulsed low mid-sequence, then 74 -> treated as non-extended, no effect. All outputs at reset values immediately on resetn=0.
